// File: rtl/div_control_fsm.sv
// Sequencing controller for a 6-iteration restoring divider: drives the
// iteration counter (E/sclr), the shift/subtract datapath and the host handshake.
module div_control_fsm (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    input  logic divisor_zero,
    input  logic r_ge_d,
    input  logic zC,
    output logic E,
    output logic sclr,
    output logic ld_regs,
    output logic shift_en,
    output logic sub_en,
    output logic busy,
    output logic done,
    output logic div0
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        TEST = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   div0_q, div0_d;

    always_comb begin
        state_d  = state_q;
        div0_d   = div0_q;
        E        = 1'b0;
        sclr     = 1'b0;
        ld_regs  = 1'b0;
        shift_en = 1'b0;
        sub_en   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    div0_d  = 1'b0;
                end
            end
            LOAD: begin
                ld_regs = 1'b1;
                E       = 1'b1;
                sclr    = 1'b1;
                busy    = 1'b1;
                if (divisor_zero) begin
                    state_d = DONE;
                    div0_d  = 1'b1;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                state_d  = TEST;
            end
            TEST: begin
                // zC reflects the count before this increment; the counter wraps to 0 as we leave
                E       = 1'b1;
                sub_en  = r_ge_d;
                busy    = 1'b1;
                state_d = zC ? DONE : ITER;
            end
            DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over every other decode and leaves the error flag alone
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            div0_d   = div0_q;
            E        = 1'b1;
            sclr     = 1'b1;
            ld_regs  = 1'b0;
            shift_en = 1'b0;
            sub_en   = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div0_q  <= div0_d;
        end
    end

    assign div0 = div0_q;

endmodule

// File: tb/tb_div_control_fsm.sv
// Directed bench for div_control_fsm with a behavioural 0..5 counter and a
// 6-bit restoring-divider datapath closing the loop around the controller.
module tb_div_control_fsm;

    logic clk = 1'b0;
    logic reset, start, abort, divisor_zero, r_ge_d, zC;
    logic E, sclr, ld_regs, shift_en, sub_en, busy, done, div0;

    logic [5:0] dvd_in, dvs_in;
    logic [6:0] rem_q;
    logic [5:0] quo_q, dvs_q;
    logic [2:0] cnt_q;

    int n_checks = 0;
    int n_pass   = 0;

    int busy_cnt, shift_cnt, sub_cnt, done_cnt, done_at, viol, e_inc, iter;
    logic [5:0] sub_mask;
    logic       busy_h [0:40];
    logic       ld_h   [0:40];
    logic       div0_h [0:40];
    logic [2:0] cnt_h  [0:40];

    div_control_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .divisor_zero (divisor_zero),
        .r_ge_d       (r_ge_d),
        .zC           (zC),
        .E            (E),
        .sclr         (sclr),
        .ld_regs      (ld_regs),
        .shift_en     (shift_en),
        .sub_en       (sub_en),
        .busy         (busy),
        .done         (done),
        .div0         (div0)
    );

    always #5 clk = ~clk;

    assign zC           = (cnt_q == 3'd5);
    assign divisor_zero = (dvs_in == 6'd0);
    assign r_ge_d       = (rem_q >= {1'b0, dvs_q});

    always @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= 3'd0;
        else if (E)
            cnt_q <= sclr ? 3'd0 : ((cnt_q == 3'd5) ? 3'd0 : cnt_q + 3'd1);
    end

    always @(posedge clk) begin
        if (ld_regs) begin
            rem_q <= 7'd0;
            quo_q <= dvd_in;
            dvs_q <= dvs_in;
        end else if (shift_en) begin
            {rem_q, quo_q} <= {rem_q[5:0], quo_q, 1'b0};
        end else if (sub_en) begin
            rem_q    <= rem_q - {1'b0, dvs_q};
            quo_q[0] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Called at a falling edge with start already set up; sample i is cycle k+i
    task automatic run_op(input int n, input bit hold, input int pulse_at);
        busy_cnt = 0; shift_cnt = 0; sub_cnt = 0; done_cnt = 0; done_at = 0;
        viol = 0; e_inc = 0; iter = 0; sub_mask = 6'd0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            busy_h[i] = busy;
            ld_h[i]   = ld_regs;
            div0_h[i] = div0;
            cnt_h[i]  = cnt_q;
            if (busy) busy_cnt++;
            if (shift_en) begin
                shift_cnt++;
                iter++;
            end
            if (sub_en) begin
                sub_cnt++;
                if (iter >= 1 && iter <= 6) sub_mask[iter-1] = 1'b1;
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            if (E && !sclr) e_inc++;
            if ((shift_en && sub_en) || (sclr && !E) || (ld_regs && (shift_en || sub_en || done)))
                viol++;
            if (i == 1 && !hold) start = 1'b0;
            if (i == pulse_at) start = 1'b1;
            else if (pulse_at > 0 && i == pulse_at + 1) start = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        dvd_in = 6'd0; dvs_in = 6'd1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {24'd0, E, sclr, ld_regs, shift_en, sub_en, busy, done, div0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        // 45 / 6 = 7 r 3; subtracts land on iterations 4, 5, 6
        dvd_in = 6'd45; dvs_in = 6'd6; start = 1'b1;
        run_op(16, 1'b0, 0);
        check("n_done_at",    done_at, 14);
        check("n_done_cnt",   done_cnt, 1);
        check("n_busy_cnt",   busy_cnt, 14);
        check("n_shift_cnt",  shift_cnt, 6);
        check("n_sub_cnt",    sub_cnt, 3);
        check("n_sub_mask",   {26'd0, sub_mask}, 32'b111000);
        check("n_quotient",   {26'd0, quo_q}, 7);
        check("n_remainder",  {25'd0, rem_q}, 3);
        check("n_ld_load",    {31'd0, ld_h[1]}, 1);
        check("n_cnt_last",   {29'd0, cnt_h[13]}, 5);
        check("n_cnt_wrap",   {29'd0, cnt_h[14]}, 0);
        check("n_e_incs",     e_inc, 6);
        check("n_idle_after", {31'd0, busy_h[15]}, 0);
        check("n_invariants", viol, 0);

        // Divide by zero
        dvd_in = 6'd45; dvs_in = 6'd0; start = 1'b1;
        run_op(6, 1'b0, 0);
        check("z_done_at",    done_at, 2);
        check("z_busy_cnt",   busy_cnt, 2);
        check("z_shift_cnt",  shift_cnt, 0);
        check("z_div0_load",  {31'd0, div0_h[1]}, 0);
        check("z_div0_done",  {31'd0, div0_h[2]}, 1);
        check("z_div0_held",  {31'd0, div0_h[6]}, 1);

        // Next start clears the error; 50 / 7 = 7 r 1
        dvd_in = 6'd50; dvs_in = 6'd7; start = 1'b1;
        run_op(16, 1'b0, 0);
        check("c_div0_clear", {31'd0, div0_h[1]}, 0);
        check("c_done_at",    done_at, 14);
        check("c_quotient",   {26'd0, quo_q}, 7);
        check("c_remainder",  {25'd0, rem_q}, 1);

        // Reset asserted during TEST of iteration 3 (cycle k+7)
        dvd_in = 6'd45; dvs_in = 6'd6; start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check("r_in_test", {30'd0, E, busy}, 32'b11);
        reset = 1'b1;
        #1;
        check("r_outputs", {25'd0, E, sclr, ld_regs, shift_en, sub_en, busy, done}, 0);
        check("r_counter", {29'd0, cnt_q}, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        run_op(16, 1'b0, 0);
        check("r_rerun_done", done_at, 14);
        check("r_rerun_busy", busy_cnt, 14);
        check("r_rerun_quo",  {26'd0, quo_q}, 7);

        // Abort in ITER of iteration 4 (cycle k+8)
        start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check("a_in_iter", {31'd0, shift_en}, 1);
        abort = 1'b1;
        #1;
        check("a_outputs", {25'd0, E, sclr, shift_en, sub_en, ld_regs, done, busy}, 32'b1100001);
        @(negedge clk);
        abort = 1'b0;
        check("a_idle",    {31'd0, busy}, 0);
        check("a_counter", {29'd0, cnt_q}, 0);
        run_op(6, 1'b0, 0);
        check("a_no_done", done_cnt, 0);
        check("a_no_busy", busy_cnt, 0);

        // start held high through DONE: one IDLE cycle then a new LOAD
        start = 1'b1;
        run_op(17, 1'b1, 0);
        check("h_done_at",  done_at, 14);
        check("h_busy_14",  {31'd0, busy_h[14]}, 1);
        check("h_idle_15",  {31'd0, busy_h[15]}, 0);
        check("h_load_16",  {31'd0, ld_h[16]}, 1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("h_aborted",  {31'd0, busy}, 0);

        // start pulse mid-division has no effect
        start = 1'b1;
        run_op(17, 1'b0, 5);
        check("p_done_at",  done_at, 14);
        check("p_busy_cnt", busy_cnt, 14);
        check("p_no_load",  {31'd0, ld_h[16]}, 0);
        check("p_invariants", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
